// File: rtl/qft3_sequencer.sv
// qft3_sequencer: start/busy/done gate-schedule sequencer driving the 3-qubit QFT datapath loads and muxes.
module qft3_sequencer #(
  parameter int sample_size = 8,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   hold,
  output logic [sample_size-1:0] LD,
  output logic                   sel_reg0,
  output logic [1:0]             sel_reg1,
  output logic [1:0]             sel_reg2,
  output logic [2:0]             sel_reg3,
  output logic [1:0]             sel_reg4,
  output logic [2:0]             sel_reg5,
  output logic [2:0]             sel_reg6,
  output logic [1:0]             sel_reg7,
  output logic [1:0]             sel_alu0_2,
  output logic                   sel_alu1_1,
  output logic                   sel_alu1_2,
  output logic                   sel_alu2_1,
  output logic                   sel_alu2_2,
  output logic [1:0]             sel_alu3_1,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             step
);
  typedef enum logic [3:0] {IDLE, LOAD, H2, R2A, R3, H1, R2B, H0, SWAP, DONE} state_t;
  state_t state, nxt;
  logic [sample_size-1:0] ld_raw;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:                         nxt = start ? LOAD : IDLE;
      LOAD, H2, R2A, R3, H1, R2B:   nxt = hold ? state : state_t'(state + 4'd1);
      H0:                           nxt = hold ? H0 : (BIT_REVERSE ? SWAP : DONE);
      SWAP:                         nxt = hold ? SWAP : DONE;
      DONE:                         nxt = start ? LOAD : IDLE;
      default:                      nxt = IDLE;
    endcase
  end
  always_comb begin
    ld_raw = '0;
    sel_reg0 = '0;
    sel_reg1 = '0;
    sel_reg2 = '0;
    sel_reg3 = '0;
    sel_reg4 = '0;
    sel_reg5 = '0;
    sel_reg6 = '0;
    sel_reg7 = '0;
    sel_alu0_2 = '0;
    sel_alu1_1 = '0;
    sel_alu1_2 = '0;
    sel_alu2_1 = '0;
    sel_alu2_2 = '0;
    sel_alu3_1 = '0;
    case (state)
      LOAD: ld_raw = 8'hFF;
      H2: begin
        ld_raw = 8'hFF;
        sel_reg0 = 1'd1;
        sel_reg1 = 2'd1;
        sel_reg2 = 2'd1;
        sel_reg3 = 3'd1;
        sel_reg4 = 2'd1;
        sel_reg5 = 3'd1;
        sel_reg6 = 3'd1;
        sel_reg7 = 2'd1;
      end
      R2A: begin
        ld_raw = 8'hC0;
        sel_reg6 = 3'd2;
        sel_reg7 = 2'd2;
      end
      R3: begin
        ld_raw = 8'hA0;
        sel_reg5 = 3'd2;
        sel_reg7 = 2'd3;
      end
      H1: begin
        ld_raw = 8'hFF;
        sel_reg0 = 1'd1;
        sel_reg1 = 2'd1;
        sel_reg2 = 2'd2;
        sel_reg3 = 3'd2;
        sel_reg4 = 2'd2;
        sel_reg5 = 3'd3;
        sel_reg6 = 3'd1;
        sel_reg7 = 2'd1;
        sel_alu0_2 = 2'd1;
        sel_alu1_2 = 1'd1;
        sel_alu2_1 = 1'd1;
        sel_alu3_1 = 2'd1;
      end
      R2B: begin
        ld_raw = 8'h88;
        sel_reg3 = 3'd3;
        sel_reg7 = 2'd2;
      end
      H0: begin
        ld_raw = 8'hFF;
        sel_reg0 = 1'd1;
        sel_reg1 = 2'd2;
        sel_reg2 = 2'd3;
        sel_reg3 = 3'd2;
        sel_reg4 = 2'd2;
        sel_reg5 = 3'd4;
        sel_reg6 = 3'd3;
        sel_reg7 = 2'd1;
        sel_alu0_2 = 2'd2;
        sel_alu1_1 = 1'd1;
        sel_alu1_2 = 1'd1;
        sel_alu2_1 = 1'd1;
        sel_alu2_2 = 1'd1;
        sel_alu3_1 = 2'd2;
      end
      SWAP: begin
        ld_raw = 8'h5A;
        sel_reg1 = 2'd3;
        sel_reg4 = 2'd3;
        sel_reg3 = 3'd4;
        sel_reg6 = 3'd4;
      end
      default: ld_raw = '0;
    endcase
  end
  // hold only gates the load enables; selects stay on the frozen gate's values
  assign busy = (state >= LOAD) && (state <= SWAP);
  assign done = (state == DONE);
  assign LD   = (hold && busy) ? '0 : ld_raw;
  assign step = (state > DONE) ? 4'd0 : state;
endmodule

// File: tb/tb_qft3_sequencer.sv
// tb_qft3_sequencer: directed checks of schedule, hold, back-to-back, reset and no-bit-reverse variant.
module tb_qft3_sequencer;
  logic clk, rst, start, hold;
  logic [7:0] LD, LD_n;
  logic sel_reg0, sel_reg0_n;
  logic [1:0] sel_reg1, sel_reg2, sel_reg4, sel_reg7, sel_reg1_n, sel_reg2_n, sel_reg4_n, sel_reg7_n;
  logic [2:0] sel_reg3, sel_reg5, sel_reg6, sel_reg3_n, sel_reg5_n, sel_reg6_n;
  logic [1:0] sel_alu0_2, sel_alu3_1, sel_alu0_2_n, sel_alu3_1_n;
  logic sel_alu1_1, sel_alu1_2, sel_alu2_1, sel_alu2_2;
  logic sel_alu1_1_n, sel_alu1_2_n, sel_alu2_1_n, sel_alu2_2_n;
  logic busy, done, busy_n, done_n;
  logic [3:0] step, step_n;
  int n_checks = 0;
  int n_fail = 0;
  bit seen_5a = 0;
  bit seen_swap = 0;
  logic [7:0] ld_exp [1:9] = '{8'hFF, 8'hFF, 8'hC0, 8'hA0, 8'hFF, 8'h88, 8'hFF, 8'h5A, 8'h00};
  logic [25:0] sels;

  qft3_sequencer #(.sample_size(8), .BIT_REVERSE(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .LD(LD),
    .sel_reg0(sel_reg0), .sel_reg1(sel_reg1), .sel_reg2(sel_reg2), .sel_reg3(sel_reg3),
    .sel_reg4(sel_reg4), .sel_reg5(sel_reg5), .sel_reg6(sel_reg6), .sel_reg7(sel_reg7),
    .sel_alu0_2(sel_alu0_2), .sel_alu3_1(sel_alu3_1), .sel_alu1_1(sel_alu1_1), .sel_alu1_2(sel_alu1_2),
    .sel_alu2_1(sel_alu2_1), .sel_alu2_2(sel_alu2_2), .busy(busy), .done(done), .step(step));

  qft3_sequencer #(.sample_size(8), .BIT_REVERSE(1'b0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .LD(LD_n),
    .sel_reg0(sel_reg0_n), .sel_reg1(sel_reg1_n), .sel_reg2(sel_reg2_n), .sel_reg3(sel_reg3_n),
    .sel_reg4(sel_reg4_n), .sel_reg5(sel_reg5_n), .sel_reg6(sel_reg6_n), .sel_reg7(sel_reg7_n),
    .sel_alu0_2(sel_alu0_2_n), .sel_alu3_1(sel_alu3_1_n), .sel_alu1_1(sel_alu1_1_n), .sel_alu1_2(sel_alu1_2_n),
    .sel_alu2_1(sel_alu2_1_n), .sel_alu2_2(sel_alu2_2_n), .busy(busy_n), .done(done_n), .step(step_n));

  assign sels = {sel_reg0, sel_reg1, sel_reg2, sel_reg3, sel_reg4, sel_reg5, sel_reg6, sel_reg7,
                 sel_alu0_2, sel_alu1_1, sel_alu1_2, sel_alu2_1, sel_alu2_2, sel_alu3_1};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (LD_n == 8'h5A) seen_5a = 1;
    if (step_n == 4'd8) seen_swap = 1;
  end

  // selects from the gate table, packed reg0..reg7 then alu0_2, alu1_1, alu1_2, alu2_1, alu2_2, alu3_1
  function automatic logic [25:0] exp_sel(input int s);
    case (s)
      2:       return {1'd1, 2'd1, 2'd1, 3'd1, 2'd1, 3'd1, 3'd1, 2'd1, 8'd0};
      3:       return {1'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, 3'd2, 2'd2, 8'd0};
      4:       return {1'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd2, 3'd0, 2'd3, 8'd0};
      5:       return {1'd1, 2'd1, 2'd2, 3'd2, 2'd2, 3'd3, 3'd1, 2'd1, 2'd1, 1'd0, 1'd1, 1'd1, 1'd0, 2'd1};
      6:       return {1'd0, 2'd0, 2'd0, 3'd3, 2'd0, 3'd0, 3'd0, 2'd2, 8'd0};
      7:       return {1'd1, 2'd2, 2'd3, 3'd2, 2'd2, 3'd4, 3'd3, 2'd1, 2'd2, 1'd1, 1'd1, 1'd1, 1'd1, 2'd2};
      8:       return {1'd0, 2'd3, 2'd0, 3'd4, 2'd3, 3'd0, 3'd4, 2'd0, 8'd0};
      default: return 26'd0;
    endcase
  endfunction

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL reset_step got %0d want 0", step); end
    n_checks++; if (LD !== 8'h00) begin n_fail++; $display("FAIL reset_ld got %h want 00", LD); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_flags got busy=%b done=%b want 0,0", busy, done); end
    n_checks++; if (sels !== 26'd0) begin n_fail++; $display("FAIL reset_sels got %h want 0", sels); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    int es, el;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 1; i <= 9; i++) begin
      n_checks++; if (step !== 4'(i)) begin n_fail++; $display("FAIL seq_step cycle %0d got %0d want %0d", i, step, i); end
      n_checks++; if (LD !== ld_exp[i]) begin n_fail++; $display("FAIL seq_ld cycle %0d got %h want %h", i, LD, ld_exp[i]); end
      n_checks++; if (done !== (i == 9)) begin n_fail++; $display("FAIL seq_done cycle %0d got %b want %b", i, done, i == 9); end
      n_checks++; if (busy !== (i <= 8)) begin n_fail++; $display("FAIL seq_busy cycle %0d got %b want %b", i, busy, i <= 8); end
      n_checks++; if (sels !== exp_sel(i)) begin n_fail++; $display("FAIL seq_sels cycle %0d got %h want %h", i, sels, exp_sel(i)); end
      es = (i <= 7) ? i : ((i == 8) ? 9 : 0);
      el = (i <= 7) ? int'(ld_exp[i]) : 0;
      n_checks++; if (step_n !== 4'(es)) begin n_fail++; $display("FAIL norev_step cycle %0d got %0d want %0d", i, step_n, es); end
      n_checks++; if (LD_n !== 8'(el)) begin n_fail++; $display("FAIL norev_ld cycle %0d got %h want %h", i, LD_n, 8'(el)); end
      n_checks++; if (done_n !== (i == 8)) begin n_fail++; $display("FAIL norev_done cycle %0d got %b want %b", i, done_n, i == 8); end
      @(negedge clk);
    end
    n_checks++; if (step !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL seq_idle got step=%0d busy=%b want 0,0", step, busy); end
  endtask

  task automatic test_hold();
    int cnt;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    hold = 1;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_checks++; if (step !== 4'd4) begin n_fail++; $display("FAIL hold_step held %0d got %0d want 4", j, step); end
      n_checks++; if (LD !== 8'h00) begin n_fail++; $display("FAIL hold_ld held %0d got %h want 00", j, LD); end
      n_checks++; if (sels !== exp_sel(4)) begin n_fail++; $display("FAIL hold_sels held %0d got %h want %h", j, sels, exp_sel(4)); end
      @(negedge clk);
    end
    hold = 0;
    #1;
    n_checks++; if (step !== 4'd4 || LD !== 8'hA0) begin n_fail++; $display("FAIL hold_release got step=%0d ld=%h want 4,a0", step, LD); end
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL hold_latency got %0d cycles want 5", cnt); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start = 1;
    @(negedge clk);
    n_checks++; if (step !== 4'd1 || LD !== 8'hFF) begin n_fail++; $display("FAIL b2b_load got step=%0d ld=%h want 1,ff", step, LD); end
    repeat (8) @(negedge clk);
    n_checks++; if (step !== 4'd9 || done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got step=%0d done=%b want 9,1", step, done); end
    @(negedge clk);
    n_checks++; if (step !== 4'd1) begin n_fail++; $display("FAIL b2b_reload got %0d want 1", step); end
    repeat (9) @(negedge clk);
    n_checks++; if (step !== 4'd1) begin n_fail++; $display("FAIL b2b_period got %0d want 1", step); end
    start = 0;
    repeat (9) @(negedge clk);
    n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL b2b_idle got %0d want 0", step); end
  endtask

  task automatic test_start_ignored();
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    n_checks++; if (step !== 4'd6) begin n_fail++; $display("FAIL busy_start got %0d want 6", step); end
    repeat (3) @(negedge clk);
    n_checks++; if (step !== 4'd9) begin n_fail++; $display("FAIL busy_start_done got %0d want 9", step); end
    @(negedge clk);
    n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL busy_start_idle got %0d want 0", step); end
  endtask

  task automatic test_mid_reset();
    int cnt;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    n_checks++; if (step !== 4'd5) begin n_fail++; $display("FAIL mrst_pre got %0d want 5", step); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_checks++; if (step !== 4'd0 || busy !== 1'b0 || LD !== 8'h00) begin n_fail++; $display("FAIL mrst_state got step=%0d busy=%b ld=%h want 0,0,00", step, busy, LD); end
    repeat (2) @(negedge clk);
    n_checks++; if (LD !== 8'h00 || step !== 4'd0) begin n_fail++; $display("FAIL mrst_quiet got step=%0d ld=%h want 0,00", step, LD); end
    start = 1;
    @(negedge clk);
    start = 0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++; if (cnt != 8) begin n_fail++; $display("FAIL mrst_rerun got %0d cycles want 8", cnt); end
    @(negedge clk);
  endtask

  task automatic test_no_reverse();
    n_checks++; if (seen_5a !== 1'b0) begin n_fail++; $display("FAIL norev_ld5a got %b want 0", seen_5a); end
    n_checks++; if (seen_swap !== 1'b0) begin n_fail++; $display("FAIL norev_swap got %b want 0", seen_swap); end
  endtask

  initial begin
    rst = 1;
    start = 0;
    hold = 0;
    test_reset();
    test_sequence();
    test_hold();
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    test_no_reverse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qft3_sequencer.md
# qft3_sequencer

Standalone control unit for the 3-qubit QFT state-vector emulation datapath (8 complex amplitudes, H add/sub ALUs, two complex-multiply ALUs for R3). It replaces the hard-wired CU FSM with a start/busy/done handshaked sequencer. The sequencer drives every register load enable and every register/ALU mux select through a fixed gate schedule: load, H, R2, R3, H, R2, H, bit-reversal swap. It also supports a pause input so a host or arbiter can freeze the datapath between gates.

## Interface
- `sample_size`, 8: amplitudes; the schedule is defined only for 8.
- `BIT_REVERSE`, 1: 1 includes the SWAP step; 0 skips it (outputs left in bit-reversed order).
- `clk` in 1: clock.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `start` in 1: request a transform; sampled only in IDLE or DONE.
- `hold` in 1: pause; freezes state and forces `LD` to 0 in compute states.
- `LD` out 8: register load enables, bit k for amplitude register k.
- `sel_reg0` out 1; `sel_reg1`, `sel_reg2`, `sel_reg4`, `sel_reg7` out 2; `sel_reg3`, `sel_reg5`, `sel_reg6` out 3: register input selects.
- `sel_alu0_2`, `sel_alu3_1` out 2; `sel_alu1_1`, `sel_alu1_2`, `sel_alu2_1`, `sel_alu2_2` out 1: ALU operand selects.
- `busy` out 1: high from LOAD through SWAP inclusive.
- `done` out 1: high for exactly the DONE state.
- `step` out 4: current state encoding (IDLE=0 … DONE=9).

## Operation
- States, in order: IDLE(0), LOAD(1), H2(2), R2A(3), R3(4), H1(5), R2B(6), H0(7), SWAP(8), DONE(9).
- Moore outputs decoded from `state`. Any select not listed for a state is 0. `LD` bits not listed are 0.
- IDLE, DONE: `LD`=0, all selects 0.
- LOAD: `LD`=8'hFF, all `sel_reg`=0 (capture `in_r`/`in_i`).
- H2: `LD`=FF, all `sel_reg`=1, all `sel_alu`=0. Butterfly pairs are (0,4), (1,5), (2,6), (3,7).
- R2A: `LD`=8'hC0, `sel_reg6`=2, `sel_reg7`=2 (multiply by i).
- R3: `LD`=8'hA0, `sel_reg5`=2, `sel_reg7`=3 (complex ALU outputs).
- H1: `LD`=FF. Register selects: reg0=1, reg1=1, reg2=2, reg3=2, reg4=2, reg5=3, reg6=1, reg7=1. ALU selects: alu0_2=1, alu1_1=0, alu1_2=1, alu2_1=1, alu2_2=0, alu3_1=1.
- R2B: `LD`=8'h88, `sel_reg3`=3, `sel_reg7`=2.
- H0: `LD`=FF. Register selects: reg0=1, reg1=2, reg2=3, reg3=2, reg4=2, reg5=4, reg6=3, reg7=1. ALU selects: alu0_2=2, alu1_1=1, alu1_2=1, alu2_1=1, alu2_2=1, alu3_1=2.
- SWAP: `LD`=8'h5A, `sel_reg1`=3, `sel_reg4`=3, `sel_reg3`=4, `sel_reg6`=4.
- Transitions:
  - IDLE→LOAD on `start`.
  - Each compute state advances to the next on `!hold`. H0→SWAP if `BIT_REVERSE`, else H0→DONE.
  - SWAP→DONE.
  - DONE→LOAD if `start`, else DONE→IDLE.
- `hold` in LOAD…SWAP: state unchanged, `LD`=0, selects keep the current state's values.
- `start` while `busy`: ignored, no queuing.
- Unused state encodings (10–15): decode as IDLE outputs, next state IDLE.

## Timing
- Reset: at the first rising edge with `rst`=1, `state`=IDLE. Outputs then read `LD`=0, all selects 0, `busy`=0, `done`=0, `step`=0. `rst` overrides `start` and `hold`.
- Reset mid-transform: the datapath registers keep their last loaded values. No further `LD` until a new `start`.
- Latency with no hold:
  - `start` high at edge t gives LOAD during cycle t+1.
  - `done` during cycle t+9 (`BIT_REVERSE`=1) or t+8 (`BIT_REVERSE`=0).
  - Results are valid in the datapath registers from the DONE cycle onward.
- Each held cycle adds exactly one cycle of latency.
- Back-to-back: `start` during DONE gives LOAD in the next cycle, with zero idle cycles.
- All control outputs change only after rising edges. No output depends combinationally on `start` or `hold`, except `LD` forced to 0 by `hold`.

## Test plan
- Reset, then pulse `start` for 1 cycle, `BIT_REVERSE`=1 → `step` runs 1,2,…,9 on consecutive cycles; `done`=1 only at step 9; `LD` sequence FF,FF,C0,A0,FF,88,FF,5A,00.
- Datapath plus sequencer, input basis state |0⟩ (in_r[0]=0x400000 at fp_bit 22, others 0) → all out_r=0x16A09E ±2 LSB, all out_i=0. Input |1⟩ → out[k] = e^{2πik/8}/√8 within ±2 LSB.
- `hold`=1 for 3 cycles during R3 → `step` stays 4 and `LD`=0 for those 3 cycles; `done` arrives 3 cycles late; results are identical to the unheld run.
- `start` held high continuously → DONE→LOAD repeats every 9 cycles; a `start` pulse during H1 does not restart the sequence.
- `rst`=1 during H1 → next cycle `step`=0, `busy`=0, `LD`=0; a later `start` completes normally.
- `BIT_REVERSE`=0 → SWAP is never entered; `done` 8 cycles after `start`; `LD` is never 5A.
